// File: rtl/word_dec.sv
// Streaming 9-bit word decryptor; 3-cycle latency from acceptance to out_valid.
// Backpressure: all stages shift together only when the output slot is free or being drained.
module word_dec #(
  parameter int KEY_W  = 144,
  parameter int WORD_W = 9,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [IDX_W-1:0]  start_idx,
  output logic              key_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx
);

  // Round key for index i: key word (16 - i) mod 16, tweaked by the index itself.
  function automatic logic [WORD_W-1:0] round_key(input logic [KEY_W-1:0] k,
                                                  input logic [IDX_W-1:0] i);
    logic [3:0] j;
    j = 4'd0 - i[3:0];
    return k[WORD_W*j +: WORD_W] ^ WORD_W'(i);
  endfunction

  function automatic logic [WORD_W-1:0] rotr3(input logic [WORD_W-1:0] x);
    return {x[2:0], x[WORD_W-1:3]};
  endfunction

  logic [KEY_W-1:0]  key_q;
  logic [IDX_W-1:0]  idx_q;

  logic              s1_vld;
  logic [IDX_W-1:0]  s1_idx;
  logic [WORD_W-1:0] s1_dat;
  logic [WORD_W-1:0] s1_k1;
  logic [WORD_W-1:0] s1_k2;

  logic              s2_vld;
  logic [IDX_W-1:0]  s2_idx;
  logic [WORD_W-1:0] s2_dat;
  logic [WORD_W-1:0] s2_k1;

  logic              adv;
  logic              any_vld;
  logic              load_req;
  logic              load_take;
  logic              accept;
  logic [WORD_W-1:0] k1;
  logic [WORD_W-1:0] k2;
  logic [WORD_W-1:0] k3;

  assign adv     = !out_valid || out_ready;
  assign any_vld = s1_vld || s2_vld || out_valid;

  // A load request on an empty pipe blocks input so the load is taken first.
  assign load_req  = key_load && !any_vld;
  assign in_ready  = adv && !rst && !load_req;
  assign accept    = in_valid && in_ready;
  assign key_ready = !any_vld && !accept;
  assign load_take = key_load && key_ready && !rst;

  always_comb begin
    k1 = round_key(key_q, idx_q - IDX_W'(1));
    k2 = round_key(key_q, idx_q);
    k3 = round_key(key_q, idx_q + IDX_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= '0;
      idx_q     <= '0;
      s1_vld    <= 1'b0;
      s1_idx    <= '0;
      s1_dat    <= '0;
      s1_k1     <= '0;
      s1_k2     <= '0;
      s2_vld    <= 1'b0;
      s2_idx    <= '0;
      s2_dat    <= '0;
      s2_k1     <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      if (load_take) begin
        key_q <= key_in;
        idx_q <= start_idx;
      end else if (accept) begin
        idx_q <= idx_q + IDX_W'(1);
      end

      if (adv) begin
        s1_vld    <= accept;
        s1_idx    <= idx_q;
        s1_dat    <= in_data - k3;
        s1_k1     <= k1;
        s1_k2     <= k2;

        s2_vld    <= s1_vld;
        s2_idx    <= s1_idx;
        s2_dat    <= rotr3(s1_dat ^ s1_k2);
        s2_k1     <= s1_k1;

        out_valid <= s2_vld;
        out_idx   <= s2_idx;
        out_data  <= s2_dat ^ s2_k1;
      end
    end
  end

endmodule

// File: tb/tb_word_dec.sv
// Directed bench for word_dec: hand-computed vectors plus encrypt-side reference streams.
module tb_word_dec;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [143:0] key_in;
  logic [6:0]   start_idx;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [8:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [8:0]   out_data;
  logic [6:0]   out_idx;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0]   pt [8];
  logic [143:0] kcur;

  localparam logic [143:0] KA = 144'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_A5C3;
  localparam logic [143:0] KB = 144'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0_5A3C;
  localparam logic [143:0] KC = 144'h1111_2222_3333_4444_5555_6666_7777_8888_9999;

  always #5 clk = ~clk;

  word_dec dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .start_idx (start_idx),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference key schedule and encryption, written from the encrypt side.
  function automatic logic [8:0] rk(input logic [143:0] k, input int i);
    int ii;
    int j;
    ii = ((i % 128) + 128) % 128;
    j  = (16 - (ii % 16)) % 16;
    return k[9*j +: 9] ^ 9'(ii);
  endfunction

  function automatic logic [8:0] enc(input logic [8:0] p, input logic [143:0] k, input int i);
    logic [8:0] t;
    t = p ^ rk(k, i - 1);
    t = {t[5:0], t[8:6]} ^ rk(k, i);
    return t + rk(k, i + 1);
  endfunction

  task automatic load(input logic [143:0] k, input logic [6:0] s);
    int n;
    key_load = 1'b1; key_in = k; start_idx = s;
    #1;
    n = 0;
    while (!key_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("load_rdy", 32'(key_ready), 1);
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic send_one(input string tag, input logic [8:0] c,
                          input logic [8:0] exp_d, input logic [6:0] exp_i);
    int n;
    in_valid = 1'b1; in_data = c;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_acc"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_lat"}, 32'(n), 3);
    check({tag, "_dat"}, 32'(out_data), 32'(exp_d));
    check({tag, "_idx"}, 32'(out_idx), 32'(exp_i));
  endtask

  task automatic stream(input string tag, input int n, input int start, input bit do_stall);
    logic [8:0] ct [8];
    int  got;
    int  k;
    int  g;
    int  mc;
    logic a;
    for (int i = 0; i < n; i++) ct[i] = enc(pt[i], kcur, start + i);
    got = 0; k = 0; g = 0; mc = 0;
    in_valid = 1'b1; in_data = ct[0];
    fork
      begin
        while (k < n && g < 100) begin
          @(negedge clk);
          a = in_ready;
          @(posedge clk); #1;
          if (a) begin
            k++;
            if (k < n) in_data = ct[k];
          end
          g++;
        end
        in_valid = 1'b0;
      end
      begin
        while (got < n && mc < 100) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            check({tag, "_dat"}, 32'(out_data), 32'(pt[got]));
            check({tag, "_idx"}, 32'(out_idx), 32'((start + got) & 127));
            got++;
          end
          mc++;
        end
      end
      begin
        if (do_stall) begin
          repeat (3) @(posedge clk);
          #1 out_ready = 1'b0;
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check({tag, "_stall_rdy"}, 32'(in_ready), 0);
            check({tag, "_stall_dat"}, 32'(out_data), 32'(pt[0]));
            check({tag, "_stall_idx"}, 32'(out_idx), 32'(start & 127));
          end
          @(posedge clk); #1;
          out_ready = 1'b1;
        end
      end
    join
    check({tag, "_cnt"}, 32'(got), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] c;
    int n;
    rst = 1'b1; key_load = 1'b0; key_in = '0; start_idx = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero key: kI=0, kII=1, kIII=2 at index 1.
    load('0, 7'd1);
    send_one("t1", 9'h003, 9'h000, 7'd1);
    load('0, 7'd1);
    send_one("t2", 9'h000, 9'h1FF, 7'd1);
    // kI=0x00F, kII=0x0BA, kIII=0x011 at index 16.
    load({135'd0, 9'h0AA}, 7'd16);
    send_one("t3", 9'h000, 9'h165, 7'd16);

    pt = '{9'h000, 9'h1FF, 9'h0A5, 9'h15A, 9'h001, 9'h100, 9'h0F0, 9'h033};
    kcur = KA;
    load(KA, 7'd127);
    stream("wrap", 3, 127, 1'b0);

    kcur = KB;
    load(KB, 7'd20);
    stream("stall", 8, 20, 1'b1);

    // Load attempt while a word is in flight must be ignored.
    load(KA, 7'd40);
    in_valid = 1'b1; in_data = enc(9'h12C, KA, 40);
    #1 check("ign_acc", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    key_load = 1'b1; key_in = KB; start_idx = 7'd50;
    #1 check("ign_key_ready", 32'(key_ready), 0);
    @(posedge clk); #1;
    key_load = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("ign_w0_dat", 32'(out_data), 32'(9'h12C));
    check("ign_w0_idx", 32'(out_idx), 40);
    send_one("ign_w1", enc(9'h0D7, KA, 41), 9'h0D7, 7'd41);

    // Load and word on the same cycle: load wins, word follows with the new key.
    @(posedge clk); #1;
    c = enc(9'h1E1, KC, 90);
    key_load = 1'b1; key_in = KC; start_idx = 7'd90;
    in_valid = 1'b1; in_data = c;
    #1;
    check("coll_in_ready", 32'(in_ready), 0);
    check("coll_key_ready", 32'(key_ready), 1);
    @(posedge clk); #1;
    key_load = 1'b0;
    send_one("coll", c, 9'h1E1, 7'd90);

    // Reset mid-stream drops in-flight words and clears key and index.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 9'h055;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    #1 check("mid_rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_idx", 32'(out_idx), 0);
    check("mid_rst_key_ready", 32'(key_ready), 1);
    send_one("post_rst", enc(9'h0B4, '0, 0), 9'h0B4, 7'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
